// File: rtl/addsub_16bit_sat_if.sv
// Operand/result bundle for addsub_16bit_sat.
//   en            capture enable for the next rising edge
//   padd/red/sub  mode selects (priority padd > red > sub > add)
//   a, b          16-bit two's-complement operands
//   s             registered 16-bit result
//   ovf, zero     registered flags, present only with ADDSUB_FLAGS_EN defined
// master: drives operands/modes and reads results. slave: the datapath.
interface addsub_16bit_sat_if;
  logic        en;
  logic        padd;
  logic        red;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] s;
`ifdef ADDSUB_FLAGS_EN
  logic        ovf;
  logic        zero;

  modport master (output en, padd, red, sub, a, b, input  s, ovf, zero);
  modport slave  (input  en, padd, red, sub, a, b, output s, ovf, zero);
`else
  modport master (output en, padd, red, sub, a, b, input  s);
  modport slave  (input  en, padd, red, sub, a, b, output s);
`endif
endinterface

// File: rtl/addsub_16bit_sat.sv
// Registered 16-bit saturating adder/subtractor.
// Modes (priority padd > red > sub > add):
//   add/sub : exact 17-bit a+b / a-b, clamped to 0x7FFF / 0x8000
//   padd    : four independent signed 4-bit lanes, each clamped to 0x7 / 0x8
//   red     : signed sum of the four bytes of a and b, sign-extended
// Ports: clk, rst (sync, active high), bus (addsub_16bit_sat_if.slave).
// Optional: define ADDSUB_FLAGS_EN to add registered ovf/zero flags.
// Result latency is one cycle; s holds while en is low.

// Signed saturating add/sub of one W-bit lane.
module addsub_sat_lane #(
  parameter int W = 4
) (
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  logic [W:0] ax, bx, sum;

  assign ax  = {a[W-1], a};
  assign bx  = {b[W-1], b};
  // One extra bit makes the result exact, including -(-2^(W-1)).
  assign sum = sub ? (ax - bx) : (ax + bx);
  // The top two bits disagree exactly when the result leaves W-bit range;
  // the extra bit is the true sign and picks the clamp direction.
  assign ovf = sum[W] ^ sum[W-1];
  assign y   = !ovf   ? sum[W-1:0] :
               sum[W] ? {1'b1, {(W-1){1'b0}}} :
                        {1'b0, {(W-1){1'b1}}};
endmodule

module addsub_16bit_sat (
  input  logic                  clk,
  input  logic                  rst,
  addsub_16bit_sat_if.slave     bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  // Parallel 4-bit lanes; no carry crosses lane boundaries.
  logic [NUM_LANES-1:0][VEC_W-1:0] pa, pb, py;
  logic [NUM_LANES-1:0]            povf;

  assign pa = bus.a;
  assign pb = bus.b;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    addsub_sat_lane #(.W(VEC_W)) u_lane (
      .sub (1'b0),
      .a   (pa[i]),
      .b   (pb[i]),
      .y   (py[i]),
      .ovf (povf[i])
    );
  end

  // Full-width add/sub.
  logic [15:0] wy;
  logic        wovf;

  addsub_sat_lane #(.W(16)) u_wide (
    .sub (bus.sub),
    .a   (bus.a),
    .b   (bus.b),
    .y   (wy),
    .ovf (wovf)
  );

  // Byte reduction: 4 x [-128,127] fits in [-512,508], 10 bits suffice.
  logic [9:0] rsum;

  assign rsum = {{2{bus.a[15]}}, bus.a[15:8]} + {{2{bus.a[7]}}, bus.a[7:0]}
              + {{2{bus.b[15]}}, bus.b[15:8]} + {{2{bus.b[7]}}, bus.b[7:0]};

  logic [15:0] nxt_s;
  logic        nxt_ovf;

  always_comb begin
    nxt_s   = wy;
    nxt_ovf = wovf;
    if (bus.padd) begin
      nxt_s   = py;
      nxt_ovf = |povf;
    end else if (bus.red) begin
      nxt_s   = {{6{rsum[9]}}, rsum};
      nxt_ovf = 1'b0;
    end
  end

  logic [15:0] s_q;
  logic        ovf_q;
  logic        zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 16'h0000;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (bus.en) begin
      s_q    <= nxt_s;
      ovf_q  <= nxt_ovf;
      zero_q <= (nxt_s == 16'h0000);
    end
  end

  assign bus.s = s_q;
`ifdef ADDSUB_FLAGS_EN
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`else
  // Flags are not exported in this build; the registers are trimmed away.
  logic unused_flags;
  assign unused_flags = ovf_q ^ zero_q;
`endif
endmodule

// File: tb/tb_addsub_16bit_sat.sv
module tb_addsub_16bit_sat;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  addsub_16bit_sat_if bus ();

  addsub_16bit_sat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] s;
    logic        ovf;
    logic        zero;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic chk   = 1'b0;
  logic chk_d = 1'b0;

  // Model state for hold cycles.
  logic [15:0] cur_s   = 16'h0000;
  logic        cur_ovf = 1'b0;
  logic        cur_zero = 1'b0;

  // Reference for the random sweep, written independently with ints.
  function automatic void ref_model(input bit p, input bit r, input bit sb,
                                    input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] rs, output logic ro);
    int acc;
    rs = 16'h0000;
    ro = 1'b0;
    if (p) begin
      for (int i = 0; i < 4; i++) begin
        logic signed [3:0] xa, xb;
        xa = a[4*i +: 4];
        xb = b[4*i +: 4];
        acc = int'(xa) + int'(xb);
        if (acc > 7)       begin acc = 7;  ro = 1'b1; end
        else if (acc < -8) begin acc = -8; ro = 1'b1; end
        rs[4*i +: 4] = acc[3:0];
      end
    end else if (r) begin
      logic signed [7:0] b0, b1, b2, b3;
      b0 = a[15:8]; b1 = a[7:0]; b2 = b[15:8]; b3 = b[7:0];
      acc = int'(b0) + int'(b1) + int'(b2) + int'(b3);
      rs  = acc[15:0];
    end else begin
      logic signed [15:0] sa, sbv;
      sa = a; sbv = b;
      acc = sb ? int'(sa) - int'(sbv) : int'(sa) + int'(sbv);
      if (acc > 32767)       begin acc = 32767;  ro = 1'b1; end
      else if (acc < -32768) begin acc = -32768; ro = 1'b1; end
      rs = acc[15:0];
    end
  endfunction

  // Drive one cycle of stimulus and queue what s should be after the edge.
  task automatic issue(input string nm, input bit r_st, input bit e,
                       input bit p, input bit r, input bit sb,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] es, input logic eo);
    exp_t x;
    @(negedge clk);
    rst = r_st; bus.en = e; bus.padd = p; bus.red = r; bus.sub = sb;
    bus.a = a; bus.b = b;
    if (r_st) begin
      cur_s = 16'h0000; cur_ovf = 1'b0; cur_zero = 1'b0;
    end else if (e) begin
      cur_s = es; cur_ovf = eo; cur_zero = (es == 16'h0000);
    end
    x.s = cur_s; x.ovf = cur_ovf; x.zero = cur_zero; x.name = nm;
    exp_q.push_back(x);
    chk = 1'b1;
  endtask

  always @(posedge clk) chk_d <= chk;

  // Monitor: every checked edge yields one result to compare.
  always @(negedge clk) begin
    if (chk_d) begin
      if (exp_q.size() == 0) begin
        $display("FAIL underflow: result seen with no expectation queued");
        n_err++;
      end else begin
        exp_t x;
        bit   bad;
        x = exp_q.pop_front();
        n_vec++;
        bad = 1'b0;
        if (bus.s !== x.s) begin
          $display("FAIL %s: s got %h want %h", x.name, bus.s, x.s);
          bad = 1'b1;
        end
`ifdef ADDSUB_FLAGS_EN
        if (bus.ovf !== x.ovf) begin
          $display("FAIL %s: ovf got %b want %b", x.name, bus.ovf, x.ovf);
          bad = 1'b1;
        end
        if (bus.zero !== x.zero) begin
          $display("FAIL %s: zero got %b want %b", x.name, bus.zero, x.zero);
          bad = 1'b1;
        end
`endif
        if (bad) n_err++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb, rs;
    logic        ro;
    bit          rp, rr, rsb, ren;

    rst = 1'b1; bus.en = 1'b0; bus.padd = 1'b0; bus.red = 1'b0; bus.sub = 1'b0;
    bus.a = 16'h0000; bus.b = 16'h0000;
    repeat (2) @(posedge clk);

    //      name          rst en  p  r  sb  a         b         s         ovf
    issue("reset0",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    issue("pre1234",      0, 1, 0, 0, 0, 16'h1000, 16'h0234, 16'h1234, 0);
    issue("rst_clr",      1, 0, 0, 0, 0, 16'h1000, 16'h0234, 16'h0000, 0);
    issue("pre1234b",     0, 1, 0, 0, 0, 16'h1000, 16'h0234, 16'h1234, 0);
    issue("rst_over_en",  1, 1, 0, 0, 0, 16'h1000, 16'h0234, 16'h0000, 0);
    issue("add_pos_sat",  0, 1, 0, 0, 0, 16'h7000, 16'h2000, 16'h7FFF, 1);
    issue("add_neg_sat",  0, 1, 0, 0, 0, 16'h9000, 16'h9000, 16'h8000, 1);
    issue("add_mixed",    0, 1, 0, 0, 0, 16'h0003, 16'hFFFE, 16'h0001, 0);
    issue("sub_neg_sat",  0, 1, 0, 0, 1, 16'h8000, 16'h0001, 16'h8000, 1);
    issue("sub_min_b",    0, 1, 0, 0, 1, 16'h0000, 16'h8000, 16'h7FFF, 1);
    issue("sub_min_min",  0, 1, 0, 0, 1, 16'h8000, 16'h8000, 16'h0000, 0);
    issue("padd_pos",     0, 1, 1, 0, 0, 16'h7878, 16'h1111, 16'h7979, 1);
    issue("padd_neg",     0, 1, 1, 0, 0, 16'h8888, 16'hFFFF, 16'h8888, 1);
    issue("padd_plain",   0, 1, 1, 0, 0, 16'h1234, 16'h1111, 16'h2345, 0);
    issue("padd_nocarry", 0, 1, 1, 0, 0, 16'h0F00, 16'h1100, 16'h1000, 0);
    issue("red_max",      0, 1, 0, 1, 0, 16'h7F7F, 16'h7F7F, 16'h01FC, 0);
    issue("red_min",      0, 1, 0, 1, 0, 16'h8080, 16'h8080, 16'hFE00, 0);
    issue("red_over_sub", 0, 1, 0, 1, 1, 16'h0101, 16'h0101, 16'h0004, 0);
    issue("hold1",        0, 0, 0, 0, 0, 16'h7000, 16'h2000, 16'h0000, 0);
    issue("hold2",        0, 0, 1, 0, 1, 16'hABCD, 16'h1357, 16'h0000, 0);
    issue("padd_over_sub",0, 1, 1, 0, 1, 16'h1111, 16'h1111, 16'h2222, 0);

    for (int i = 0; i < 500; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rp  = ($urandom_range(0, 3) == 0);
      rr  = ($urandom_range(0, 2) == 0);
      rsb = $urandom_range(0, 1) == 1;
      ren = ($urandom_range(0, 7) != 0);
      if (i % 50 == 0) begin ra = 16'h8000; rb = 16'h8000; end
      ref_model(rp, rr, rsb, ra, rb, rs, ro);
      issue("random", 0, ren, rp, rr, rsb, ra, rb, rs, ro);
    end

    @(negedge clk);
    chk = 1'b0;
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
